// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between instruction and data requesters:
// data-priority grant locked until accept, in-order response routing via an owner FIFO.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             slv_req,
  output logic             slv_wr,
  output logic [1:0]       slv_size,
  output logic [31:0]      slv_addr,
  output logic [3:0]       slv_wstrb,
  output logic [31:0]      slv_wdata,
  input  logic             slv_addr_ok,
  input  logic             slv_data_ok,
  input  logic [31:0]      slv_rdata,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             resp_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOCK_D, S_LOCK_I} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;
  logic             owner_mem [OUTSTANDING];

  logic fifo_full, fifo_empty;
  logic grant_data, grant_inst;
  logic push, pop, head_owner;

  assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);

  // Grants are forced off while reset is asserted so no request escapes during reset.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (resetn) begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_full) begin
            if (data_req)      grant_data = 1'b1;
            else if (inst_req) grant_inst = 1'b1;
          end
        end
        S_LOCK_D: grant_data = 1'b1;
        S_LOCK_I: grant_inst = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    slv_req   = ~fifo_full & ((grant_data & data_req) | (grant_inst & inst_req));
    slv_wr    = 1'b0;
    slv_size  = '0;
    slv_addr  = '0;
    slv_wstrb = '0;
    slv_wdata = '0;
    if (grant_data) begin
      slv_wr    = data_wr;
      slv_size  = data_size;
      slv_addr  = data_addr;
      slv_wstrb = data_wstrb;
      slv_wdata = data_wdata;
    end else if (grant_inst) begin
      slv_wr    = inst_wr;
      slv_size  = inst_size;
      slv_addr  = inst_addr;
      slv_wstrb = inst_wstrb;
      slv_wdata = inst_wdata;
    end
  end

  assign push         = slv_req & slv_addr_ok;
  assign pop          = slv_data_ok & ~fifo_empty;
  assign head_owner   = owner_mem[rptr_q];
  assign data_addr_ok = grant_data & push;
  assign inst_addr_ok = grant_inst & push;
  assign data_data_ok = pop & head_owner;
  assign inst_data_ok = pop & ~head_owner;
  assign inst_rdata   = resetn ? slv_rdata : '0;
  assign data_rdata   = resetn ? slv_rdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data && !push)      state_d = S_LOCK_D;
        else if (grant_inst && !push) state_d = S_LOCK_I;
      end
      S_LOCK_D, S_LOCK_I: begin
        if (push) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A response with nothing outstanding is dropped and latched as an error.
  always_comb begin
    wptr_d     = wptr_q + PTR_W'(push);
    rptr_d     = rptr_q + PTR_W'(pop);
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    resp_err_d = resp_err_q | (slv_data_ok & fifo_empty);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) owner_mem[wptr_q] <= grant_data;
  end

  assign outstanding_cnt = cnt_q;
  assign resp_err        = resp_err_q;

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one SRAM-like slave port between the core's instruction requester and data requester. The core's instruction and data interfaces connect on the master side; the slave side feeds the SRAM-like-to-AXI bridge. Arbitration is data-priority and locked per request. Response routing is in-order via an outstanding-owner FIFO, so no ID is needed on the slave side.

Parameters:
OUTSTANDING, 4, maximum accepted-but-unanswered requests (power of 2, 2..16)
CNT_W, 3, width of outstanding count; must equal clog2(OUTSTANDING)+1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  instruction request
inst_wr  in  1  instruction write flag
inst_size  in  2  instruction access size
inst_addr  in  32  instruction physical address
inst_wstrb  in  4  instruction byte strobes
inst_wdata  in  32  instruction write data
inst_addr_ok  out  1  instruction request accepted
inst_data_ok  out  1  instruction response valid
inst_rdata  out  32  instruction read data
data_req  in  1  data request
data_wr  in  1  data write flag
data_size  in  2  data access size
data_addr  in  32  data physical address
data_wstrb  in  4  data byte strobes
data_wdata  in  32  data write data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
slv_req  out  1  slave request
slv_wr  out  1  slave write flag
slv_size  out  2  slave access size
slv_addr  out  32  slave address
slv_wstrb  out  4  slave byte strobes
slv_wdata  out  32  slave write data
slv_addr_ok  in  1  slave accepted request
slv_data_ok  in  1  slave response valid
slv_rdata  in  32  slave read data
outstanding_cnt  out  CNT_W  current FIFO occupancy
resp_err  out  1  sticky flag: response arrived with no outstanding request

Behaviour:
- Reset (async, resetn=0): lock state IDLE, FIFO empty, outstanding_cnt=0, resp_err=0. All *_addr_ok, *_data_ok and slv_req are 0; all data outputs are 0.
- Lock FSM, three states:
  - IDLE: if FIFO is not full, grant data when data_req=1, else inst when inst_req=1. Grant is combinational in the same cycle.
  - If the granted request is not accepted (slv_addr_ok=0), go to LOCK_D or LOCK_I.
  - LOCK_D / LOCK_I: grant is held to that master regardless of the other's req. Return to IDLE in the cycle slv_addr_ok=1.
  - Masters keep req and payload stable until addr_ok; the arbiter does not check this.
- Slave request: slv_req = granted master's req AND FIFO not full. slv_wr, size, addr, wstrb and wdata mux from the granted master. With no grant they are 0.
- Full FIFO in a LOCK state: slv_req is forced 0 and the lock is kept.
- addr_ok routing: granted master's addr_ok = slv_addr_ok AND slv_req; the other master's addr_ok=0. Zero added latency.
- Accept (slv_req and slv_addr_ok both 1): push the owner bit (1=data, 0=inst) into the FIFO.
- Response (slv_data_ok=1 with FIFO non-empty): pop the head. head=1 gives data_data_ok=1; head=0 gives inst_data_ok=1. rdata goes to both masters unmodified; only data_ok is qualified. Zero latency.
- Push and pop in the same cycle: occupancy unchanged; the pointers wrap modulo OUTSTANDING. A push while the FIFO is full is impossible because slv_req is gated.
- Pop with an empty FIFO, including a response arriving in the same cycle as the first accept: ignored, no master data_ok, resp_err<=1 until reset. The slave never answers in the accept cycle.
- Ordering: responses return strictly in acceptance order; the slave must guarantee this.
- Flushes: the core's discard counters sit downstream of inst_data_ok/data_data_ok. The arbiter never drops responses.
- Reset mid-operation: all state clears immediately; responses for pre-reset requests then set resp_err.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000, slv_addr_ok=1 in cycle 0 -> slv_addr=0xBFC00000, inst_addr_ok=1 in cycle 0. Then slv_data_ok=1 in cycle 3 with rdata=0x3C1D8000 -> inst_data_ok=1, inst_rdata=0x3C1D8000, outstanding_cnt 1->0.
- Simultaneous requests: inst_req and data_req both 1, slv_addr_ok=1 -> data granted first (data_addr_ok=1, inst_addr_ok=0); inst granted the next cycle. Responses in order -> data_data_ok, then inst_data_ok.
- Lock hold: inst_req=1 alone with slv_addr_ok=0 for 3 cycles; data_req rises in cycle 1 -> slv_addr stays inst_addr until the inst accept in cycle 3; data is granted in cycle 4.
- FIFO full: 4 inst accepts with no responses -> outstanding_cnt=4, slv_req=0 despite data_req=1. One slv_data_ok -> cnt=3; data accepted the next cycle.
- Same-cycle push and pop at cnt=2 -> cnt stays 2; routing stays correct across pointer wrap after 10 mixed transactions.
- Spurious response: slv_data_ok=1 with cnt=0 -> no master data_ok, resp_err=1 and held. resetn=0 -> resp_err=0.
